// File: rtl/idec_cpsr_unit_pkg.sv
// Shared definitions for the instruction decode / status register slice.
// Holds datapath widths, the PC register index, ALU opcode and condition
// code encodings, flag bit positions and the condition evaluation helper.
package idec_cpsr_unit_pkg;

  localparam int FULLW  = 32;
  localparam int FLAGSW = 4;
  localparam int REGAW  = 4;
  localparam int ALUAW  = 4;
  localparam int PC_IDX = 15;

  // Flag positions inside the {N,Z,C,V} nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
    ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
    ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
    ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [FLAGSW-1:0] flags);
    logic n, z, c, v;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond_e'(cond))
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpsr32.sv
// Status register: only the N,Z,C,V bits are stored, each with its own load
// enable; the low 28 bits of the presented word are constant zero.
// Ports: clk, rst_n, flags_in {N,Z,C,V}, set_en {N,Z,C,V}, cpsr_out.
module cpsr32
  import idec_cpsr_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAGSW-1:0] flags_in,
  input  logic [FLAGSW-1:0] set_en,
  output logic [FULLW-1:0]  cpsr_out
);

  logic [FLAGSW-1:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= (set_en & flags_in) | (~set_en & flags_q);
  end

  assign cpsr_out = {flags_q, {(FULLW-FLAGSW){1'b0}}};

endmodule

// File: rtl/dff.sv
// Generic WIDTH-bit register with asynchronous active-low reset to zero.
// Ports: clk, rst_n, d (next value), q (registered value).
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/idec32.sv
// Combinational instruction decoder for data-processing, load/store and
// branch encodings. Conditional execution uses the current flags; ispb
// squashes the instruction in the shadow of a taken branch.
// Ports: iin, flags {N,Z,C,V}, ispb in; ALU opcode, register fields, flag
// set enables, write enables and branch controls out.
module idec32
  import idec_cpsr_unit_pkg::*;
(
  input  logic [FULLW-1:0]  iin,
  input  logic [FLAGSW-1:0] flags,
  input  logic              ispb,
  output logic [ALUAW-1:0]  alu_out,
  output logic [REGAW-1:0]  rn_out,
  output logic [REGAW-1:0]  rd_out,
  output logic [FLAGSW-1:0] cpsrs_out,
  output logic              reg_we,
  output logic              mem_we,
  output logic              ib,
  output logic [FULLW-1:0]  bv,
  output logic              bl
);

  logic             valid;
  logic [ALUAW-1:0] op;
  logic             is_test;
  logic             is_arith;

  always_comb begin
    valid    = cond_pass(iin[31:28], flags) && !ispb;
    op       = iin[24:21];
    // TST/TEQ/CMP/CMN only produce flags, never a register result.
    is_test  = (op[3:2] == 2'b10);
    // Opcodes that go through the adder and so produce meaningful C and V.
    is_arith = ((op >= 4'h2) && (op <= 4'h7)) || (op == ALU_CMP) || (op == ALU_CMN);

    alu_out   = '0;
    rn_out    = iin[19:16];
    rd_out    = iin[15:12];
    cpsrs_out = '0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    ib        = 1'b0;
    bl        = 1'b0;
    bv        = '0;

    if (iin[27:26] == 2'b00) begin
      alu_out = op;
      reg_we  = valid && !is_test;
      if (valid && iin[20])
        cpsrs_out = is_arith ? 4'b1111 : 4'b1100;
    end else if (iin[27:26] == 2'b01) begin
      // U bit picks whether the offset is added to or subtracted from the base.
      alu_out = iin[23] ? ALU_ADD : ALU_SUB;
      mem_we  = valid && !iin[20];
      reg_we  = valid && iin[20];
    end else if (iin[27:25] == 3'b101) begin
      ib = valid;
      bl = valid && iin[24];
      bv = {{(FULLW-26){iin[23]}}, iin[23:0], 2'b00};
    end
  end

endmodule

// File: rtl/idec_cpsr_unit.sv
// Decode plus status-register slice: combinational decoder, N/Z/C/V register
// with per-flag load enables, and a one-cycle branch shadow flag that squashes
// the instruction following a taken branch.
// Ports: clk, nreset (async active-low), iin, alu_flags in; alu_out, rn_out,
// rd_out, cpsrs_out, reg_we, mem_we, ib, bv, bl, cpsr_out, ispb_out out.
module idec_cpsr_unit #(
  parameter int FULLW  = idec_cpsr_unit_pkg::FULLW,
  parameter int FLAGSW = idec_cpsr_unit_pkg::FLAGSW,
  parameter int REGAW  = idec_cpsr_unit_pkg::REGAW,
  parameter int ALUAW  = idec_cpsr_unit_pkg::ALUAW
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [FULLW-1:0]  iin,
  input  logic [FLAGSW-1:0] alu_flags,
  output logic [ALUAW-1:0]  alu_out,
  output logic [REGAW-1:0]  rn_out,
  output logic [REGAW-1:0]  rd_out,
  output logic [FLAGSW-1:0] cpsrs_out,
  output logic              reg_we,
  output logic              mem_we,
  output logic              ib,
  output logic [FULLW-1:0]  bv,
  output logic              bl,
  output logic [FULLW-1:0]  cpsr_out,
  output logic              ispb_out
);

  import idec_cpsr_unit_pkg::*;

  idec32 u_idec (
    .iin       (iin),
    .flags     (cpsr_out[31:28]),
    .ispb      (ispb_out),
    .alu_out   (alu_out),
    .rn_out    (rn_out),
    .rd_out    (rd_out),
    .cpsrs_out (cpsrs_out),
    .reg_we    (reg_we),
    .mem_we    (mem_we),
    .ib        (ib),
    .bv        (bv),
    .bl        (bl)
  );

  cpsr32 u_cpsr (
    .clk      (clk),
    .rst_n    (nreset),
    .flags_in (alu_flags),
    .set_en   (cpsrs_out),
    .cpsr_out (cpsr_out)
  );

  dff #(.WIDTH(1)) u_ispb (
    .clk   (clk),
    .rst_n (nreset),
    .d     (ib),
    .q     (ispb_out)
  );

endmodule

// File: tb/tb_idec_cpsr_unit.sv
// Bench for idec_cpsr_unit: directed instruction scenarios followed by
// randomized instruction streams, all compared against a behavioural model.
module tb_idec_cpsr_unit;

  logic        clk = 1'b0;
  logic        nreset;
  logic [31:0] iin;
  logic [3:0]  alu_flags;
  logic [3:0]  alu_out;
  logic [3:0]  rn_out;
  logic [3:0]  rd_out;
  logic [3:0]  cpsrs_out;
  logic        reg_we;
  logic        mem_we;
  logic        ib;
  logic [31:0] bv;
  logic        bl;
  logic [31:0] cpsr_out;
  logic        ispb_out;

  idec_cpsr_unit dut (
    .clk       (clk),
    .nreset    (nreset),
    .iin       (iin),
    .alu_flags (alu_flags),
    .alu_out   (alu_out),
    .rn_out    (rn_out),
    .rd_out    (rd_out),
    .cpsrs_out (cpsrs_out),
    .reg_we    (reg_we),
    .mem_we    (mem_we),
    .ib        (ib),
    .bv        (bv),
    .bl        (bl),
    .cpsr_out  (cpsr_out),
    .ispb_out  (ispb_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Model state: architectural flags {N,Z,C,V} and the branch-shadow bit.
  logic [3:0] m_flags;
  bit         m_ispb;

  logic [3:0]  e_alu, e_rn, e_rd, e_cpsrs;
  logic        e_reg_we, e_mem_we, e_ib, e_bl;
  logic [31:0] e_bv;

  // Conditions come in true/inverted pairs; the odd member inverts the even one.
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    if (c[0]) r = !r;
    return r;
  endfunction

  task automatic ref_decode(input logic [31:0] i);
    bit v;
    int op;
    int off;
    v = ref_cond(i[31:28], m_flags) && !m_ispb;
    e_alu = 4'd0; e_rn = i[19:16]; e_rd = i[15:12]; e_cpsrs = 4'd0;
    e_reg_we = 0; e_mem_we = 0; e_ib = 0; e_bl = 0; e_bv = 32'd0;
    if (i[27:26] == 2'b00) begin
      op = int'(i[24:21]);
      e_alu = i[24:21];
      e_reg_we = v && !(op >= 8 && op <= 11);
      if (v && i[20])
        e_cpsrs = ((op >= 2 && op <= 7) || op == 10 || op == 11) ? 4'hF : 4'hC;
    end else if (i[27:26] == 2'b01) begin
      e_alu = i[23] ? 4'd4 : 4'd2;
      e_mem_we = v && !i[20];
      e_reg_we = v && i[20];
    end else if (i[27:25] == 3'b101) begin
      e_ib = v;
      e_bl = v && i[24];
      off = int'({{8{i[23]}}, i[23:0]});
      e_bv = 32'(off * 4);
    end
  endtask

  task automatic compare_all();
    check("alu_out",   32'(alu_out),   32'(e_alu));
    check("rn_out",    32'(rn_out),    32'(e_rn));
    check("rd_out",    32'(rd_out),    32'(e_rd));
    check("cpsrs_out", 32'(cpsrs_out), 32'(e_cpsrs));
    check("reg_we",    32'(reg_we),    32'(e_reg_we));
    check("mem_we",    32'(mem_we),    32'(e_mem_we));
    check("ib",        32'(ib),        32'(e_ib));
    check("bv",        bv,             e_bv);
    check("bl",        32'(bl),        32'(e_bl));
    check("cpsr_out",  cpsr_out,       {m_flags, 28'h0});
    check("ispb_out",  32'(ispb_out),  32'(m_ispb));
  endtask

  // Called just after a rising edge; checks at the falling edge.
  task automatic step(input logic [31:0] i, input logic [3:0] f);
    iin = i;
    alu_flags = f;
    ref_decode(i);
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (e_cpsrs[k]) m_flags[k] = alu_flags[k];
    m_ispb = e_ib;
    #1;
  endtask

  initial begin
    logic [31:0] body;
    logic [3:0]  cond;
    int          cls;

    nreset = 1'b0;
    iin = 32'hE0912003;
    alu_flags = 4'h0;
    m_flags = 4'h0;
    m_ispb = 0;
    #2;
    check("rst_cpsr", cpsr_out, 32'h0);
    check("rst_ispb", 32'(ispb_out), 32'h0);
    ref_decode(iin);
    compare_all();
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;

    // ADDS r2,r1,r3
    step(32'hE0912003, 4'b0110);
    check("adds_alu", 32'(alu_out), 32'h4);
    check("adds_rn", 32'(rn_out), 32'h1);
    check("adds_rd", 32'(rd_out), 32'h2);
    check("adds_we", 32'(reg_we), 32'h1);
    check("adds_cpsrs", 32'(cpsrs_out), 32'hF);
    advance();
    check("adds_cpsr", cpsr_out, 32'h60000000);

    // ADDEQ with Z clear, then with Z set
    step(32'hE0912003, 4'b0000);
    advance();
    check("z_clear", cpsr_out, 32'h0);
    step(32'h00812003, 4'b0000);
    check("addeq_z0", 32'(reg_we), 32'h0);
    advance();
    step(32'hE0912003, 4'b0100);
    advance();
    check("z_set", cpsr_out, 32'h40000000);
    step(32'h00812003, 4'b0000);
    check("addeq_z1", 32'(reg_we), 32'h1);
    advance();

    // CMP r1,r2
    step(32'hE1510002, 4'b0000);
    check("cmp_we", 32'(reg_we), 32'h0);
    check("cmp_cpsrs", 32'(cpsrs_out), 32'hF);
    check("cmp_alu", 32'(alu_out), 32'hA);
    advance();

    // Taken branch, then squashed ADDS, then shadow clears
    step(32'hEAFFFFFE, 4'b0000);
    check("b_ib", 32'(ib), 32'h1);
    check("b_bv", bv, 32'hFFFFFFF8);
    check("b_bl", 32'(bl), 32'h0);
    advance();
    check("b_ispb", 32'(ispb_out), 32'h1);
    step(32'hE0912003, 4'b1111);
    check("sq_we", 32'(reg_we), 32'h0);
    check("sq_cpsrs", 32'(cpsrs_out), 32'h0);
    advance();
    check("sq_ispb", 32'(ispb_out), 32'h0);

    // STR / LDR
    step(32'hE5812000, 4'b0000);
    check("str_mem", 32'(mem_we), 32'h1);
    check("str_we", 32'(reg_we), 32'h0);
    check("str_alu", 32'(alu_out), 32'h4);
    advance();
    step(32'hE5912000, 4'b0000);
    check("ldr_we", 32'(reg_we), 32'h1);
    check("ldr_mem", 32'(mem_we), 32'h0);
    advance();

    // Async reset mid-cycle with all flags set and the shadow bit set
    step(32'hE0912003, 4'b1111);
    advance();
    check("all_flags", cpsr_out, 32'hF0000000);
    step(32'hEBFFFFFE, 4'b0000);
    check("bl_bl", 32'(bl), 32'h1);
    advance();
    #2 nreset = 1'b0;
    #1;
    check("async_cpsr", cpsr_out, 32'h0);
    check("async_ispb", 32'(ispb_out), 32'h0);
    m_flags = 4'h0;
    m_ispb = 0;
    @(posedge clk);
    #1 nreset = 1'b1;

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      cond = ($urandom_range(0, 9) < 6) ? 4'hE : 4'($urandom_range(0, 15));
      cls  = int'($urandom_range(0, 3));
      body = $urandom;
      case (cls)
        0: body[27:26] = 2'b00;
        1: body[27:26] = 2'b01;
        2: body[27:25] = 3'b101;
        default: ;
      endcase
      step({cond, body[27:0]}, 4'($urandom_range(0, 15)));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/idec_cpsr_unit.md
IDEC_CPSR_UNIT -- requirements
Module: idec_cpsr_unit

Interface
REQ-001 SHALL have parameters: FULLW, 32, datapath width; FLAGSW, 4, flag count {N,Z,C,V}; REGAW, 4, register address width; ALUAW, 4, ALU opcode width.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock (one clock); nreset  in  1  reset, asynchronous, active-low.
REQ-003 iin  in  FULLW  current instruction; alu_flags  in  FLAGSW  ALU result flags {N,Z,C,V}.
REQ-004 alu_out  out  ALUAW  ALU opcode; rn_out  out  REGAW  first source register; rd_out  out  REGAW  destination/second register.
REQ-005 cpsrs_out  out  FLAGSW  per-flag set enables {N,Z,C,V}; reg_we  out  1  register write enable; mem_we  out  1  memory write enable.
REQ-006 ib  out  1  branch taken; bv  out  FULLW  branch byte offset; bl  out  1  branch-with-link; cpsr_out  out  FULLW  status register; ispb_out  out  1  previous-cycle-branch flag.

Function
REQ-007 Decode SHALL be purely combinational from iin, cpsr_out[31:28] and ispb_out.
REQ-008 cond=iin[31:28] SHALL be evaluated per ARM table (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL); 1111 SHALL never pass.
REQ-009 valid SHALL be cond_pass AND NOT ispb_out; every enable output (reg_we, mem_we, cpsrs_out, ib, bl) SHALL be 0 when valid=0.
REQ-010 Data processing (iin[27:26]=00): alu_out=iin[24:21], rn_out=iin[19:16], rd_out=iin[15:12]; reg_we=valid unless opcode is TST/TEQ/CMP/CMN (1000-1011).
REQ-011 Data processing with S=iin[20]=1: cpsrs_out=1111 for arithmetic opcodes (0010-0111, 1010, 1011), 1100 (N,Z only) for all other opcodes.
REQ-012 Load/store (iin[27:26]=01): rn_out=iin[19:16], rd_out=iin[15:12]; alu_out=0100 (ADD) when U=iin[23]=1, else 0010 (SUB); mem_we=valid AND NOT iin[20]; reg_we=valid AND iin[20].
REQ-013 Branch (iin[27:25]=101): ib=valid; bl=valid AND iin[24]; bv=sign-extended iin[23:0] shifted left 2; reg_we=0.
REQ-014 bv SHALL be 0 for non-branch instructions; all other encodings SHALL drive every enable 0, alu_out=0, rn_out/rd_out from iin fields.
REQ-015 On each clk rising edge, for each i with cpsrs_out[i]=1, cpsr_out[28+i] SHALL load alu_flags[i]; unset bits SHALL hold.
REQ-016 cpsr_out[27:0] SHALL always be 0.
REQ-017 ispb_out SHALL be a 1-bit register loading ib each rising clk edge (one-instruction squash after taken branch).
REQ-018 A branch immediately following a taken branch SHALL be squashed (ib=0), so ispb_out clears the following cycle.

Reset
REQ-019 nreset=0 SHALL asynchronously clear cpsr_out to 0x00000000 and ispb_out to 0, independent of clk.
REQ-020 Combinational outputs SHALL reflect iin with cleared state during reset; state updates SHALL resume on the first rising edge after nreset deasserts.

Structure
REQ-021 FULLW, FLAGSW, REGAW, ALUAW, PC index (15) and ALU opcode/cond-code constants SHALL live in the shared defines package.
REQ-022 Sub-modules: idec32 (combinational decoder), cpsr32 (flag register with per-bit enables), dff (parameterised WIDTH flop with async active-low reset) for ispb.

Verification
REQ-023 Reset, iin=0xE0912003 (ADDS r2,r1,r3), alu_flags=0110 -> alu_out=0100, rn_out=1, rd_out=2, reg_we=1, cpsrs_out=1111; after edge cpsr_out=0x60000000.
REQ-024 cpsr Z=0, iin=0x00812003 (ADDEQ) -> reg_we=0; with Z=1 (cpsr_out=0x40000000) -> reg_we=1.
REQ-025 iin=0xE1510002 (CMP r1,r2) -> reg_we=0, cpsrs_out=1111, alu_out=1010.
REQ-026 iin=0xEAFFFFFE -> ib=1, bv=0xFFFFFFF8, bl=0; next cycle ispb_out=1 and iin=0xE0912003 gives reg_we=0, cpsrs_out=0000; following cycle ispb_out=0.
REQ-027 iin=0xE5812000 (STR) -> mem_we=1, reg_we=0, alu_out=0100; iin=0xE5912000 (LDR) -> reg_we=1, mem_we=0.
REQ-028 cpsr_out=0xF0000000, assert nreset=0 mid-cycle -> cpsr_out=0 and ispb_out=0 immediately, before next clk edge.
